// File: rtl/corePckg.sv
// Shared core definitions: ALU operation encoding, branch funct3 codes and
// the default datapath width.
package corePckg;

  localparam int unsigned cXLEN = 32;

  // ALU operations; encodings above eNoOp are undefined and produce zero.
  typedef enum logic [3:0] {
    eAdd,
    eSub,
    eShftLeft,
    eCompareSigned,
    eCompareUnsigned,
    eXor,
    eShftRight,
    eShftRightArit,
    eOr,
    eAnd,
    eNoOp
  } tArithEnum;

  // RISC-V conditional branch funct3 encodings.
  localparam logic [2:0] cBrEq  = 3'b000;
  localparam logic [2:0] cBrNe  = 3'b001;
  localparam logic [2:0] cBrLt  = 3'b100;
  localparam logic [2:0] cBrGe  = 3'b101;
  localparam logic [2:0] cBrLtu = 3'b110;
  localparam logic [2:0] cBrGeu = 3'b111;

  // Branch decision from precomputed compare flags; unknown funct3 is not taken.
  function automatic logic brDecide(input logic [2:0] funct3,
                                    input logic       eq,
                                    input logic       ltS,
                                    input logic       ltU);
    logic taken;
    case (funct3)
      cBrEq:   taken = eq;
      cBrNe:   taken = !eq;
      cBrLt:   taken = ltS;
      cBrGe:   taken = !ltS;
      cBrLtu:  taken = ltU;
      cBrGeu:  taken = !ltU;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One register slice of the ALU pipeline: a valid bit plus an opaque payload,
// both advancing only when the whole pipe advances.
module alu_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iFlush,
  input  logic             iValid,
  input  logic [Width-1:0] iData,
  output logic             oValid,
  output logic [Width-1:0] oData
);

  logic             validQ;
  logic [Width-1:0] dataQ;

  // Valid follows upstream on enable; flush wins over both enable and stall.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      validQ <= 1'b0;
    end else if (iFlush) begin
      validQ <= 1'b0;
    end else if (iEn) begin
      validQ <= iValid;
    end
  end

  // Payload only captured for real operations so idle outputs stay quiet.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      dataQ <= '0;
    end else if (iEn && iValid) begin
      dataQ <= iData;
    end
  end

  assign oValid = validQ;
  assign oData  = dataQ;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer ALU with branch resolution. Stage 1 computes the result;
// the remaining STAGES-1 stages are plain register slices. The whole pipe
// stalls as one unit under downstream back-pressure.
module alu_pipe
  import corePckg::*;
#(
  parameter int unsigned XLEN   = cXLEN,
  parameter int unsigned STAGES = 2,
  parameter int unsigned REGW   = 5
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iValid,
  output logic            oReady,
  input  tArithEnum       iOp,
  input  logic [XLEN-1:0] iOperand1,
  input  logic [XLEN-1:0] iOperand2,
  input  logic [REGW-1:0] iRdAddr,
  input  logic            iBrValid,
  input  logic [2:0]      iBrFunct3,
  input  logic [XLEN-1:0] iBrTarget,
  input  logic            iFlush,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oData,
  output logic [REGW-1:0] oRdAddr,
  output logic            oBrTaken,
  output logic [XLEN-1:0] oBrPc
);

  localparam int unsigned ShW  = $clog2(XLEN);
  // Payload layout: {data, rdAddr, brTaken, brPc}
  localparam int unsigned PayW = XLEN + REGW + 1 + XLEN;

  logic            advance;
  logic [ShW-1:0]  shamt;
  logic            opEq;
  logic            opLtS;
  logic            opLtU;
  logic [XLEN-1:0] aluResult;

  logic [XLEN-1:0] s1Data;
  logic [REGW-1:0] s1Rd;
  logic            s1BrTaken;
  logic [XLEN-1:0] s1BrPc;
  logic [PayW-1:0] s1PayD;

  logic            s1ValidQ;
  logic [PayW-1:0] s1PayQ;

  logic            chainValid [STAGES];
  logic [PayW-1:0] chainPay   [STAGES];

  logic            brTakenRaw;

  // Pipe moves whenever the output slot is empty or being consumed.
  assign advance = !oValid || iReady;
  assign oReady  = advance;

  assign shamt = iOperand2[ShW-1:0];
  assign opEq  = (iOperand1 == iOperand2);
  assign opLtS = ($signed(iOperand1) < $signed(iOperand2));
  assign opLtU = (iOperand1 < iOperand2);

  // Stage-1 arithmetic; undefined encodings fall through to zero.
  always_comb begin
    aluResult = '0;
    case (iOp)
      eAdd:             aluResult = iOperand1 + iOperand2;
      eSub:             aluResult = iOperand1 - iOperand2;
      eShftLeft:        aluResult = iOperand1 << shamt;
      eCompareSigned:   aluResult = {{(XLEN-1){1'b0}}, opLtS};
      eCompareUnsigned: aluResult = {{(XLEN-1){1'b0}}, opLtU};
      eXor:             aluResult = iOperand1 ^ iOperand2;
      eShftRight:       aluResult = iOperand1 >> shamt;
      eShftRightArit:   aluResult = $signed(iOperand1) >>> shamt;
      eOr:              aluResult = iOperand1 | iOperand2;
      eAnd:             aluResult = iOperand1 & iOperand2;
      eNoOp:            aluResult = iOperand1;
      default:          aluResult = '0;
    endcase
  end

  // Branches write no register: data and destination are forced to zero.
  always_comb begin
    s1Data    = aluResult;
    s1Rd      = iRdAddr;
    s1BrTaken = 1'b0;
    s1BrPc    = '0;
    if (iBrValid) begin
      s1Data    = '0;
      s1Rd      = '0;
      s1BrTaken = brDecide(iBrFunct3, opEq, opLtS, opLtU);
      s1BrPc    = iBrTarget;
    end
    s1PayD = {s1Data, s1Rd, s1BrTaken, s1BrPc};
  end

  // Stage-1 valid: flush drops in-flight work and any input offered alongside.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      s1ValidQ <= 1'b0;
    end else if (iFlush) begin
      s1ValidQ <= 1'b0;
    end else if (advance) begin
      s1ValidQ <= iValid;
    end
  end

  // Stage-1 payload captured only on an accepted operation.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      s1PayQ <= '0;
    end else if (advance && iValid) begin
      s1PayQ <= s1PayD;
    end
  end

  assign chainValid[0] = s1ValidQ;
  assign chainPay[0]   = s1PayQ;

  for (genvar s = 1; s < STAGES; s++) begin : gStage
    alu_pipe_stage #(
      .Width(PayW)
    ) uStage (
      .iClk  (iClk),
      .iRst  (iRst),
      .iEn   (advance),
      .iFlush(iFlush),
      .iValid(chainValid[s-1]),
      .iData (chainPay[s-1]),
      .oValid(chainValid[s]),
      .oData (chainPay[s])
    );
  end

  assign oValid = chainValid[STAGES-1];
  assign {oData, oRdAddr, brTakenRaw, oBrPc} = chainPay[STAGES-1];
  // Last taken flag lingers in the register after the slot empties.
  assign oBrTaken = oValid && brTakenRaw;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a STAGES=2 instance carries most checks and a
// STAGES=3 instance covers deeper-pipe latency and flush of two in-flight ops.
module tb_alu_pipe;
  import corePckg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  logic            iClk = 1'b0;
  logic            iRst = 1'b0;
  logic            iValid;
  tArithEnum       iOp;
  logic [XLEN-1:0] iOperand1;
  logic [XLEN-1:0] iOperand2;
  logic [REGW-1:0] iRdAddr;
  logic            iBrValid;
  logic [2:0]      iBrFunct3;
  logic [XLEN-1:0] iBrTarget;
  logic            iFlush;
  logic            iReady;

  logic            oReady, oValid, oBrTaken;
  logic [XLEN-1:0] oData, oBrPc;
  logic [REGW-1:0] oRdAddr;

  logic            o3Ready, o3Valid, o3BrTaken;
  logic [XLEN-1:0] o3Data, o3BrPc;
  logic [REGW-1:0] o3RdAddr;

  int checkCount = 0;
  int errorCount = 0;

  always #5 iClk = ~iClk;

  alu_pipe #(.XLEN(XLEN), .STAGES(2), .REGW(REGW)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iOp(iOp),
    .iOperand1(iOperand1), .iOperand2(iOperand2), .iRdAddr(iRdAddr),
    .iBrValid(iBrValid), .iBrFunct3(iBrFunct3), .iBrTarget(iBrTarget),
    .iFlush(iFlush), .oValid(oValid), .iReady(iReady), .oData(oData),
    .oRdAddr(oRdAddr), .oBrTaken(oBrTaken), .oBrPc(oBrPc)
  );

  alu_pipe #(.XLEN(XLEN), .STAGES(3), .REGW(REGW)) dut3 (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(o3Ready), .iOp(iOp),
    .iOperand1(iOperand1), .iOperand2(iOperand2), .iRdAddr(iRdAddr),
    .iBrValid(iBrValid), .iBrFunct3(iBrFunct3), .iBrTarget(iBrTarget),
    .iFlush(iFlush), .oValid(o3Valid), .iReady(iReady), .oData(o3Data),
    .oRdAddr(o3RdAddr), .oBrTaken(o3BrTaken), .oBrPc(o3BrPc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output collector for the back-pressure test: one entry per transfer out.
  logic            collect = 1'b0;
  logic [XLEN-1:0] gotData [$];
  logic [REGW-1:0] gotRd   [$];
  always @(negedge iClk) begin
    if (collect && oValid && iReady) begin
      gotData.push_back(oData);
      gotRd.push_back(oRdAddr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    iValid    = 1'b0;
    iOp       = eNoOp;
    iOperand1 = '0;
    iOperand2 = '0;
    iRdAddr   = '0;
    iBrValid  = 1'b0;
    iBrFunct3 = 3'b000;
    iBrTarget = '0;
    iFlush    = 1'b0;
  endtask

  // Present one op for one edge, then wait (bounded) for oValid on the main DUT.
  task automatic runOp(input tArithEnum op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [REGW-1:0] rd, input logic brV, input logic [2:0] f3,
                       input logic [XLEN-1:0] tgt, output int lat);
    iValid = 1'b1; iOp = op; iOperand1 = a; iOperand2 = b; iRdAddr = rd;
    iBrValid = brV; iBrFunct3 = f3; iBrTarget = tgt;
    @(posedge iClk); #1;
    iValid = 1'b0; iBrValid = 1'b0;
    lat = 1;
    while (!oValid && lat < 10) begin
      @(posedge iClk); #1;
      lat++;
    end
  endtask

  typedef struct {
    tArithEnum       op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } tVec;

  typedef struct {
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            taken;
  } tBrVec;

  tVec   vecs   [13];
  tBrVec brVecs [7];

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{eAdd,             32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1]  = '{eSub,             32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
    vecs[2]  = '{eShftLeft,        32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
    vecs[3]  = '{eShftRightArit,   32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
    vecs[4]  = '{eShftRight,       32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
    vecs[5]  = '{eCompareSigned,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[6]  = '{eCompareUnsigned, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[7]  = '{eXor,             32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0};
    vecs[8]  = '{eOr,              32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0};
    vecs[9]  = '{eAnd,             32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    vecs[10] = '{eNoOp,            32'h1234_5678, 32'h0000_0009, 32'h1234_5678};
    vecs[11] = '{tArithEnum'(4'd12), 32'h1234_5678, 32'h0000_0009, 32'h0000_0000};
    vecs[12] = '{eShftRightArit,   32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF};

    brVecs[0] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};  // BLT
    brVecs[1] = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};  // BLTU
    brVecs[2] = '{3'b000, 32'h0000_0005, 32'h0000_0005, 1'b1};  // BEQ
    brVecs[3] = '{3'b001, 32'h0000_0005, 32'h0000_0005, 1'b0};  // BNE
    brVecs[4] = '{3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};  // BGE
    brVecs[5] = '{3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};  // BGEU
    brVecs[6] = '{3'b010, 32'h0000_0005, 32'h0000_0005, 1'b0};  // undefined

    idle();
    iReady = 1'b1;
    iRst   = 1'b0;

    // Reset state
    repeat (2) @(posedge iClk);
    #1;
    check("rst_oValid",   oValid,   1'b0);
    check("rst_oReady",   oReady,   1'b1);
    check("rst_oData",    oData,    '0);
    check("rst_oRdAddr",  oRdAddr,  '0);
    check("rst_oBrTaken", oBrTaken, 1'b0);
    check("rst_oBrPc",    oBrPc,    '0);
    @(negedge iClk);
    iRst = 1'b1;
    @(posedge iClk); #1;

    // ALU operations, latency and destination echo
    for (int i = 0; i < 13; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, REGW'(i + 1), 1'b0, 3'b000, '0, lat);
      check($sformatf("alu%0d_lat", i), lat, 2);
      check($sformatf("alu%0d_data", i), oData, vecs[i].exp);
      check($sformatf("alu%0d_rd", i), oRdAddr, REGW'(i + 1));
      @(posedge iClk); #1;
    end

    // Branches: data/rd forced to zero, target passed through, taken gated by valid
    for (int i = 0; i < 7; i++) begin
      runOp(eAdd, brVecs[i].a, brVecs[i].b, 5'd9, 1'b1, brVecs[i].f3,
            32'h100 + 32'(i * 4), lat);
      check($sformatf("br%0d_lat", i), lat, 2);
      check($sformatf("br%0d_taken", i), oBrTaken, brVecs[i].taken);
      check($sformatf("br%0d_pc", i), oBrPc, 32'h100 + 32'(i * 4));
      check($sformatf("br%0d_data", i), oData, '0);
      check($sformatf("br%0d_rd", i), oRdAddr, '0);
      @(posedge iClk); #1;
      check($sformatf("br%0d_idleTaken", i), oBrTaken, 1'b0);
    end

    // Back-to-back ops with a 3-cycle downstream stall after the first result
    gotData.delete();
    gotRd.delete();
    collect = 1'b1;
    fork
      begin : drvOps
        for (int k = 0; k < 4; k++) begin
          logic acc;
          int   guard;
          iValid = 1'b1; iOp = eAdd; iOperand1 = 32'(k); iOperand2 = 32'd10;
          iRdAddr = REGW'(k + 1);
          acc = 1'b0;
          guard = 0;
          while (!acc && guard < 20) begin
            @(negedge iClk);
            acc = oReady;
            @(posedge iClk); #1;
            guard++;
          end
        end
        iValid = 1'b0;
      end
      begin : stallOut
        int w;
        w = 0;
        while (!oValid && w < 20) begin
          @(posedge iClk); #1;
          w++;
        end
        check("stall_firstLat", w, 2);
        iReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge iClk);
          check($sformatf("stall%0d_valid", c), oValid, 1'b1);
          check($sformatf("stall%0d_data", c), oData, 32'd10);
          check($sformatf("stall%0d_rd", c), oRdAddr, 5'd1);
          check($sformatf("stall%0d_ready", c), oReady, 1'b0);
          @(posedge iClk); #1;
        end
        iReady = 1'b1;
      end
    join
    for (int w = 0; w < 10 && gotData.size() < 4; w++) begin
      @(posedge iClk); #1;
    end
    repeat (2) @(posedge iClk);
    #1;
    collect = 1'b0;
    check("b2b_count", gotData.size(), 4);
    for (int k = 0; k < 4 && k < gotData.size(); k++) begin
      check($sformatf("b2b%0d_data", k), gotData[k], 32'(k + 10));
      check($sformatf("b2b%0d_rd", k), gotRd[k], REGW'(k + 1));
    end

    // Drain both instances
    idle();
    repeat (6) @(posedge iClk);
    #1;

    // Flush: two ops in flight in the 3-stage instance plus one offered alongside
    iValid = 1'b1; iOp = eAdd; iOperand1 = 32'd1; iOperand2 = 32'd2; iRdAddr = 5'd3;
    @(posedge iClk); #1;
    iOperand1 = 32'd4;
    @(posedge iClk); #1;
    iOperand1 = 32'd7;
    iFlush = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    iFlush = 1'b0;
    check("flush_mainValid", oValid, 1'b0);
    check("flush_deepValid", o3Valid, 1'b0);
    seen = 0;
    repeat (5) begin
      @(posedge iClk); #1;
      if (o3Valid) seen++;
      if (oValid) seen++;
    end
    check("flush_noneOut", seen, 0);

    // Normal op after flush through the 3-stage instance
    iValid = 1'b1; iOp = eXor; iOperand1 = 32'h0000_F0F0; iOperand2 = 32'h0000_FF00;
    iRdAddr = 5'd4;
    @(posedge iClk); #1;
    iValid = 1'b0;
    lat = 1;
    while (!o3Valid && lat < 10) begin
      @(posedge iClk); #1;
      lat++;
    end
    check("postFlush_lat3", lat, 3);
    check("postFlush_data3", o3Data, 32'h0000_0FF0);
    check("postFlush_rd3", o3RdAddr, 5'd4);
    repeat (3) @(posedge iClk);
    #1;

    // Asynchronous reset mid-stream
    iValid = 1'b1; iOp = eAdd; iOperand1 = 32'h11; iOperand2 = 32'h22; iRdAddr = 5'd6;
    @(posedge iClk); #1;
    iOp = eSub;
    @(posedge iClk); #1;
    iValid = 1'b0;
    check("preRst_valid", oValid, 1'b1);
    check("preRst_data", oData, 32'h33);
    #3;
    iRst = 1'b0;
    #1;
    check("midRst_oValid",   oValid,   1'b0);
    check("midRst_oData",    oData,    '0);
    check("midRst_oRdAddr",  oRdAddr,  '0);
    check("midRst_oBrTaken", oBrTaken, 1'b0);
    check("midRst_oBrPc",    oBrPc,    '0);
    check("midRst_oReady",   oReady,   1'b1);
    @(negedge iClk);
    iRst = 1'b1;
    @(posedge iClk); #1;
    check("postRst_idle", oValid, 1'b0);
    runOp(eXor, 32'h0000_F0F0, 32'h0000_FF00, 5'd2, 1'b0, 3'b000, '0, lat);
    check("postRst_lat", lat, 2);
    check("postRst_data", oData, 32'h0000_0FF0);
    check("postRst_rd", oRdAddr, 5'd2);
    @(posedge iClk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
